// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: weight format, loader state encoding and default filter size.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int K_DEFAULT = 5;

  typedef logic signed [DATA_W-1:0] weight_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STROBE,
    RELEASE,
    DONE
  } loader_state_e;

endpackage

// File: rtl/filter_stream_loader.sv
// Assembles a KxK filter from a row-major weight stream and commits it to the
// filter buffer through its read/finish handshake, with an acknowledge timeout.
//
// state   | meaning
// IDLE    | waiting for start; filter_out holds the last filter
// FILL    | accepting stream words into filter_out[row][col]
// STROBE  | buf_read high, waiting for buf_finish to rise
// RELEASE | buf_read low, waiting for buf_finish to fall
// DONE    | one-cycle done pulse, then back to IDLE
module filter_stream_loader #(
  parameter int K       = cnn_pkg::K_DEFAULT,
  parameter int DATA_W  = cnn_pkg::DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_W-1:0]         in_data,
  output logic [K-1:0][K-1:0][DATA_W-1:0]  filter_out,
  output logic                             buf_read,
  input  logic                             buf_finish,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  import cnn_pkg::loader_state_e;
  import cnn_pkg::IDLE;
  import cnn_pkg::FILL;
  import cnn_pkg::STROBE;
  import cnn_pkg::RELEASE;
  import cnn_pkg::DONE;

  localparam int CW     = (K > 1) ? $clog2(K) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     IDX_LAST  = CW'(K - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  loader_state_e                      r_state;
  logic [CW-1:0]                      r_row;
  logic [CW-1:0]                      r_col;
  logic [K-1:0][K-1:0][DATA_W-1:0]    r_filter;
  logic                               r_in_ready;
  logic                               r_buf_read;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_err;
  logic [WAIT_W-1:0]                  r_wait;

  logic w_accept;
  logic w_last;
  logic w_waiting;
  logic w_wait_tc;

  assign w_accept  = in_valid && r_in_ready;
  assign w_last    = (r_row == IDX_LAST) && (r_col == IDX_LAST);
  assign w_waiting = ((r_state == STROBE) && !buf_finish) ||
                     ((r_state == RELEASE) && buf_finish);
  assign w_wait_tc = (r_wait == '0);

  // Down-counter reloads whenever the FSM is not stuck waiting, so every
  // entry into STROBE or RELEASE starts a fresh TIMEOUT-cycle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= WAIT_LOAD;
    end else if (w_waiting && !w_wait_tc) begin
      r_wait <= r_wait - 1'b1;
    end else begin
      r_wait <= WAIT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_filter   <= '0;
      r_in_ready <= 1'b0;
      r_buf_read <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= FILL;
            r_row      <= '0;
            r_col      <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_filter[r_row][r_col] <= in_data;
            if (w_last) begin
              r_state    <= STROBE;
              r_in_ready <= 1'b0;
              r_buf_read <= 1'b1;
              r_row      <= '0;
              r_col      <= '0;
            end else if (r_col == IDX_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        STROBE: begin
          if (buf_finish) begin
            r_state    <= RELEASE;
            r_buf_read <= 1'b0;
          end else if (w_wait_tc) begin
            r_state    <= IDLE;
            r_buf_read <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
          end
        end
        RELEASE: begin
          if (!buf_finish) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_wait_tc) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_buf_read <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign filter_out = r_filter;
  assign in_ready   = r_in_ready;
  assign buf_read   = r_buf_read;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_filter_stream_loader.sv
// Randomized bench for filter_stream_loader (K=5 and K=3 instances) against a
// timeline model derived from the handshake rules, with a buffer acknowledge model.
module tb_filter_stream_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                        start5, in_valid5, in_ready5, buf_read5, buf_finish5;
  logic                        busy5, done5, err5;
  logic signed [15:0]          in_data5;
  logic [4:0][4:0][15:0]       filter5;

  logic                        start3, in_valid3, in_ready3, buf_read3, buf_finish3;
  logic                        busy3, done3, err3;
  logic signed [15:0]          in_data3;
  logic [2:0][2:0][15:0]       filter3;

  filter_stream_loader #(.K(5), .DATA_W(16), .TIMEOUT(64)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .filter_out(filter5), .buf_read(buf_read5), .buf_finish(buf_finish5),
    .busy(busy5), .done(done5), .err(err5)
  );

  filter_stream_loader #(.K(3), .DATA_W(16), .TIMEOUT(64)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .filter_out(filter3), .buf_read(buf_read3), .buf_finish(buf_finish3),
    .busy(busy3), .done(done3), .err(err3)
  );

  // Buffer model: finish follows read half a cycle later when acknowledging.
  logic ack5;
  always @(negedge clk) begin
    buf_finish5 = ack5 & buf_read5;
    buf_finish3 = buf_read3;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] mdl5 [25];
  logic        err_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_filter5();
    for (int i = 0; i < 25; i++)
      check("filter5_word", 32'(filter5[i/5][i%5]), 32'(mdl5[i]));
  endtask

  // mode 0: contiguous words 1..25; mode 1: valid every other cycle; mode 2: random valid.
  task automatic run5(input int mode, input bit ack, input bit spur);
    int acc = 0, stalls = 0, last = -1, done_at = -1;
    logic v;
    logic [15:0] w;
    logic e_ready, e_read, e_done, e_busy, e_err;
    ack5 = ack;
    @(posedge clk); #1;
    check("err_before_start", 32'(err5), 32'(err_exp));
    in_valid5 = spur;
    in_data5  = 16'sh7abc;
    start5    = 1'b1;
    @(posedge clk); #1;
    start5  = 1'b0;
    err_exp = 1'b0;
    check("busy_after_start", 32'(busy5), 32'd1);
    check("ready_after_start", 32'(in_ready5), 32'd1);
    check("err_cleared_by_start", 32'(err5), 32'd0);
    for (int n = 1; n < 300; n++) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
      if (mode == 0)       w = 16'(acc + 1);
      else if (acc == 3)   w = 16'hFFFF;
      else if (acc == 17)  w = 16'h8000;
      else                 w = 16'($urandom);
      in_valid5 = (acc < 25) ? v : 1'($urandom_range(0, 1));
      in_data5  = w;
      start5    = spur && (n == 5 || (last >= 0 && n == last + 3));
      @(posedge clk); #1;
      if (acc < 25) begin
        if (v) begin
          mdl5[acc] = w;
          acc++;
          if (acc == 25) last = n;
        end else begin
          stalls++;
        end
      end
      e_ready = (acc < 25);
      e_read  = (last >= 0) && (ack ? (n == last) : (n - last < 64));
      e_done  = ack && (last >= 0) && (n == last + 2);
      e_busy  = !((last >= 0) && (n >= last + (ack ? 3 : 64)));
      e_err   = !ack && (last >= 0) && (n >= last + 64);
      check("in_ready", 32'(in_ready5), 32'(e_ready));
      check("buf_read", 32'(buf_read5), 32'(e_read));
      check("done", 32'(done5), 32'(e_done));
      check("busy", 32'(busy5), 32'(e_busy));
      check("err", 32'(err5), 32'(e_err));
      if (done5 && done_at < 0) done_at = n;
      if (last >= 0 && n >= last + (ack ? 4 : 66)) break;
    end
    start5    = 1'b0;
    in_valid5 = 1'b0;
    check("last_accept_edge", 32'(last), 32'(25 + stalls));
    check("done_edge", 32'(done_at), ack ? 32'(27 + stalls) : 32'hFFFF_FFFF);
    if (!ack) err_exp = 1'b1;
    check_filter5();
  endtask

  initial begin
    int done_at;
    rst_n = 1'b0;
    start5 = 0; in_valid5 = 0; in_data5 = '0; ack5 = 1'b1; buf_finish5 = 0;
    start3 = 0; in_valid3 = 0; in_data3 = '0; buf_finish3 = 0;
    err_exp = 1'b0;
    #1;
    check("rst_filter5", 32'(filter5 != '0), 32'd0);
    check("rst_busy5", 32'(busy5), 32'd0);
    check("rst_ready5", 32'(in_ready5), 32'd0);
    check("rst_read5", 32'(buf_read5), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    in_valid5 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ready_low", 32'(in_ready5), 32'd0);
    end
    in_valid5 = 1'b0;

    run5(0, 1'b1, 1'b0);
    check("basic_00", 32'(filter5[0][0]), 32'd1);
    check("basic_04", 32'(filter5[0][4]), 32'd5);
    check("basic_44", 32'(filter5[4][4]), 32'd25);
    run5(1, 1'b1, 1'b0);
    check("sign_ffff", 32'(filter5[0][3]), 32'hFFFF);
    check("sign_8000", 32'(filter5[3][2]), 32'h8000);
    run5(2, 1'b1, 1'b1);
    run5(2, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("err_sticky", 32'(err5), 32'd1);
    end
    run5(0, 1'b1, 1'b0);

    // Reset after 12 accepted words.
    @(posedge clk); #1; start5 = 1'b1;
    @(posedge clk); #1; start5 = 1'b0; in_valid5 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data5 = 16'(100 + i);
      @(posedge clk); #1;
    end
    in_valid5 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_filter", 32'(filter5 != '0), 32'd0);
    check("midrst_ready", 32'(in_ready5), 32'd0);
    check("midrst_busy", 32'(busy5), 32'd0);
    check("midrst_read", 32'(buf_read5), 32'd0);
    check("midrst_done", 32'(done5), 32'd0);
    err_exp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run5(0, 1'b1, 1'b0);
    repeat (3) run5(2, 1'b1, 1'b1);

    // K=3 instance, words 10..18 back to back.
    @(posedge clk); #1; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    done_at = -1;
    for (int n = 1; n < 40; n++) begin
      in_valid3 = (n <= 9);
      in_data3  = 16'(9 + n);
      @(posedge clk); #1;
      if (done3 && done_at < 0) done_at = n;
    end
    in_valid3 = 1'b0;
    check("k3_done_edge", 32'(done_at), 32'd11);
    check("k3_00", 32'(filter3[0][0]), 32'd10);
    check("k3_12", 32'(filter3[1][2]), 32'd15);
    check("k3_22", 32'(filter3[2][2]), 32'd18);
    check("k3_busy_end", 32'(busy3), 32'd0);
    check("k3_err", 32'(err3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
